nco_multi_wave: RTL and testbench
=================================

Name: nco_multi_wave

Overview:
Time-multiplexed, multi-channel numerically controlled oscillator for the audio test path.
- Each channel has its own PHASE_BITS phase accumulator, frequency word, waveform mode and gain.
- On every sample_tick the block emits one signed PCM sample per channel, channel 0 first, on a valid/ready stream toward the PCM serialiser.
- Sine uses a quarter-wave ROM with symmetry reconstruction.

Parameters:
NUM_CH, 2, number of channels (1..16)
PHASE_BITS, 24, phase accumulator / frequency word width
TABLE_BITS, 8, phase MSBs used for lookup; ROM holds 2^(TABLE_BITS-2) entries
AMP_BITS, 16, signed output sample width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
sample_tick  in  1  one-cycle sample-rate strobe
phase_clr  in  1  synchronous clear of all phase accumulators
freq_word  in  NUM_CH*PHASE_BITS  per-channel phase increment, ch0 in LSBs
mode  in  NUM_CH*2  per-channel waveform: 00 sine, 01 square, 10 saw, 11 mute
gain  in  NUM_CH*8  per-channel unsigned gain, 128 = unity
out_valid  out  1  sample available
out_ready  in  1  downstream accept
out_ch  out  max(1,clog2(NUM_CH))  channel of out_data
out_data  out  AMP_BITS  signed sample
busy  out  1  frame in progress
overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset: all accumulators 0, FSM IDLE. out_valid=0, out_data=0, out_ch=0, busy=0, overrun=0. Reset mid-frame abandons the frame immediately.
- Accumulators:
  - On every sample_tick, each channel's phase <= phase + freq_word, modulo 2^PHASE_BITS. The wrap is silent. This happens even when the tick is dropped, so frequency stays exact.
  - phase_clr has priority over the tick. It zeroes all accumulators at the next edge and does not abort a frame in flight.
- Snapshot: the frame uses each channel's phase value from before the tick's increment, latched at the tick.
- FSM: IDLE -> LOOKUP -> SCALE -> OUT -> (LOOKUP for next channel | IDLE after last).
  - IDLE + sample_tick: latch phases, ch=0, go to LOOKUP, busy=1.
  - LOOKUP: sample mode/gain of the current channel, issue the registered ROM read.
  - SCALE: apply gain and saturate into the output register.
  - OUT: out_valid=1. On out_valid && out_ready, either increment ch and go to LOOKUP, or clear busy and go to IDLE.
- Latency: tick sampled at edge T gives ch0 out_valid in cycle T+3. Each later channel is valid 3 cycles after the previous handshake. Minimum frame is 3*NUM_CH cycles.
- Stream rules:
  - out_data and out_ch hold stable while out_valid && !out_ready.
  - out_valid is never withdrawn without a handshake.
- Mid-frame config: mode/gain changes take effect for channels not yet in LOOKUP.
- Overrun: sample_tick while busy sets overrun. The tick is dropped for output only. overrun is cleared only by rst.
- Sine, with idx = top TABLE_BITS of phase, quadrant q = idx[MSB:MSB-1], address a = low TABLE_BITS-2 bits:
  - q odd uses address ~a.
  - q >= 2 negates the value.
  - ROM[a] = round((2^(AMP_BITS-1)-1) * sin(2*pi*(a+0.5)/2^TABLE_BITS)). The half-step offset gives exact mirror symmetry.
- Square: phase MSB 0 gives +(2^(AMP_BITS-1)-1); MSB 1 gives -(2^(AMP_BITS-1)-1).
- Saw: top AMP_BITS of phase with MSB inverted, read as signed. Phase 0 gives -2^(AMP_BITS-1).
- Mute: 0.
- Gain: signed product (AMP_BITS+9 bits) arithmetic-shifted right by 7 (floor), then saturated to [-2^(AMP_BITS-1), 2^(AMP_BITS-1)-1].

Decomposition:
- Package nco_pkg:
  - waveform mode constants
  - UNITY_GAIN = 128, GAIN_SHIFT = 7
  - saturate function
  - quarter-table init function (real-valued, simulation/elab time)
- Sub-module sine_quarter_rom: registered quarter-wave read plus quadrant mirror/negate. Its one-cycle latency is absorbed by the LOOKUP state.

Test Plan:
- Defaults, ch0 sine gain 128, freq_word 0x010000, out_ready=1, two ticks -> ch0 samples 402 then 1206, first out_valid exactly 3 cycles after the first tick edge.
- phase_clr, then ch0 sine freq_word 0x800000 -> alternating +402 (idx 0) and -402 (idx 128); ch1 mute -> 0 every frame; out_ch sequence 0,1,0,1.
- ch0 square gain 255 -> 32767 (saturated from 65278); ch1 saw at phase 0 gain 128 -> -32768.
- out_ready held low 10 cycles during ch0 OUT -> out_data/out_ch stable, no ch1 output, accumulators still advance on ticks; overrun=1 if a tick lands while busy.
- freq_word 0xFFFFFF, 2^24+1 ticks (or preload via phase_clr and repeated ticks) -> phase wraps silently, sine sequence continuous.
- rst asserted in SCALE of ch1 -> same cycle out_valid=0, busy=0, overrun=0, out_data=0; next tick restarts at ch0 with phase 0.

Source files
------------

// File: rtl/nco_multi_wave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nco_pkg
//  Description : Shared constants, state encoding and helper functions for
//                the multi-channel numerically controlled oscillator.
//  Revision    : 1.0  initial release
// ============================================================================
package nco_pkg;

  // Waveform selection codes (two bits per channel)
  localparam logic [1:0] MODE_SINE   = 2'b00;
  localparam logic [1:0] MODE_SQUARE = 2'b01;
  localparam logic [1:0] MODE_SAW    = 2'b10;
  localparam logic [1:0] MODE_MUTE   = 2'b11;

  // Gain is Q1.7 unsigned: 128 is unity, so products are shifted right by 7
  localparam int UNITY_GAIN = 128;
  localparam int GAIN_SHIFT = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_SCALE  = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  // Clamp a wide signed value into the signed range of amp_bits
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int amp_bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (amp_bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (amp_bits - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

  // One quarter-wave table entry, evaluated at elaboration time.
  // The half-step offset makes the quadrant mirror exact.
  function automatic int quarter_entry(input int a, input int table_bits,
                                       input int amp_bits);
    real full;
    real ang;
    full = (2.0 ** (amp_bits - 1)) - 1.0;
    ang  = 2.0 * 3.14159265358979323846 * (real'(a) + 0.5) / (2.0 ** table_bits);
    return $rtoi(full * $sin(ang) + 0.5);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nco_multi_wave_if.sv
`default_nettype none
// ============================================================================
//  Module      : nco_multi_wave_if
//  Description : Valid/ready PCM sample stream carrying channel tag and data.
//  Revision    : 1.0  initial release
// ============================================================================
interface nco_multi_wave_if #(
  parameter int NUM_CH   = 2,
  parameter int AMP_BITS = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                       out_valid;
  logic                       out_ready;
  logic [CH_W-1:0]            out_ch;
  logic signed [AMP_BITS-1:0] out_data;

  modport master (output out_valid, output out_ch, output out_data, input out_ready);
  modport slave  (input out_valid, input out_ch, input out_data, output out_ready);
endinterface
`default_nettype wire

// File: rtl/nco_multi_wave_sine_quarter_rom.sv
`default_nettype none
// ============================================================================
//  Module      : sine_quarter_rom
//  Description : Registered quarter-wave sine lookup with quadrant mirroring
//                (odd quadrants read the table backwards) and negation
//                (lower half-cycle).
//  Revision    : 1.0  initial release
// ============================================================================
module sine_quarter_rom
  import nco_pkg::*;
#(
  parameter int TABLE_BITS = 8,
  parameter int AMP_BITS   = 16
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       i_en,
  input  wire logic [TABLE_BITS-1:0]      i_idx,
  output logic signed [AMP_BITS-1:0]      o_data
);

  localparam int c_DEPTH = 2 ** (TABLE_BITS - 2);

  logic signed [AMP_BITS-1:0] w_rom [c_DEPTH];
  logic [1:0]                 w_quad;
  logic [TABLE_BITS-3:0]      w_a;
  logic [TABLE_BITS-3:0]      w_addr;
  logic signed [AMP_BITS-1:0] w_mag;

  for (genvar g = 0; g < c_DEPTH; g++) begin : g_rom
    localparam int c_VAL = quarter_entry(g, TABLE_BITS, AMP_BITS);
    assign w_rom[g] = c_VAL[AMP_BITS-1:0];
  end

  assign w_quad = i_idx[TABLE_BITS-1 -: 2];
  assign w_a    = i_idx[TABLE_BITS-3:0];
  assign w_addr = w_quad[0] ? ~w_a : w_a;
  assign w_mag  = w_rom[w_addr];

  // Registered read; sign applied for the second half of the cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       o_data <= '0;
    else if (i_en) o_data <= w_quad[1] ? -w_mag : w_mag;
  end

endmodule
`default_nettype wire

// File: rtl/nco_multi_wave.sv
`default_nettype none
// ============================================================================
//  Module      : nco_multi_wave
//  Description : Time-multiplexed multi-channel NCO. Each sample_tick
//                snapshots all phase accumulators and streams one gained,
//                saturated sample per channel (channel 0 first).
//  Revision    : 1.0  initial release
// ============================================================================
module nco_multi_wave
  import nco_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int PHASE_BITS = 24,
  parameter int TABLE_BITS = 8,
  parameter int AMP_BITS   = 16
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic                         i_sample_tick,
  input  wire logic                         i_phase_clr,
  input  wire logic [NUM_CH*PHASE_BITS-1:0] i_freq_word,
  input  wire logic [NUM_CH*2-1:0]          i_mode,
  input  wire logic [NUM_CH*8-1:0]          i_gain,
  nco_multi_wave_if.master                  o_pcm,
  output logic                              o_busy,
  output logic                              o_overrun
);

  localparam int                c_CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [c_CH_W-1:0] c_LAST_CH = c_CH_W'(NUM_CH - 1);
  localparam int                c_PROD_W  = AMP_BITS + 9;
  localparam logic signed [AMP_BITS-1:0] c_POS_FS = {1'b0, {(AMP_BITS-1){1'b1}}};
  localparam logic signed [AMP_BITS-1:0] c_NEG_FS = {1'b1, {(AMP_BITS-2){1'b0}}, 1'b1};

  logic [PHASE_BITS-1:0] w_freq  [NUM_CH];
  logic [1:0]            w_mode  [NUM_CH];
  logic [7:0]            w_gain  [NUM_CH];
  logic [PHASE_BITS-1:0] r_phase [NUM_CH];
  logic [PHASE_BITS-1:0] r_snap  [NUM_CH];

  state_t                     r_state;
  logic [c_CH_W-1:0]          r_ch;
  logic [1:0]                 r_mode;
  logic [7:0]                 r_gain;
  logic                       r_valid;
  logic                       r_busy;
  logic                       r_overrun;
  logic signed [AMP_BITS-1:0] r_data;

  logic                       w_start;
  logic [AMP_BITS-1:0]        w_top;
  logic [TABLE_BITS-1:0]      w_idx;
  logic                       w_rom_en;
  logic signed [AMP_BITS-1:0] w_sine;
  logic signed [AMP_BITS-1:0] w_wave;
  logic signed [c_PROD_W-1:0] w_wave_x;
  logic signed [c_PROD_W-1:0] w_gain_x;
  logic signed [c_PROD_W-1:0] w_prod;
  logic signed [c_PROD_W-1:0] w_scaled;
  logic signed [63:0]         w_scaled_ext;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_freq[g] = i_freq_word[g*PHASE_BITS +: PHASE_BITS];
    assign w_mode[g] = i_mode[g*2 +: 2];
    assign w_gain[g] = i_gain[g*8 +: 8];
  end

  assign w_start = i_sample_tick && (r_state == ST_IDLE);

  // Phase accumulators: clear wins over tick; dropped ticks still advance phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) r_phase[i] <= '0;
    end else if (i_phase_clr) begin
      for (int i = 0; i < NUM_CH; i++) r_phase[i] <= '0;
    end else if (i_sample_tick) begin
      for (int i = 0; i < NUM_CH; i++) r_phase[i] <= r_phase[i] + w_freq[i];
    end
  end

  // Frame snapshot of pre-increment phases, taken when a frame starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) r_snap[i] <= '0;
    end else if (w_start) begin
      for (int i = 0; i < NUM_CH; i++) r_snap[i] <= r_phase[i];
    end
  end

  // Phase bits of the channel being processed
  assign w_top    = r_snap[r_ch][PHASE_BITS-1 -: AMP_BITS];
  assign w_idx    = w_top[AMP_BITS-1 -: TABLE_BITS];
  assign w_rom_en = (r_state == ST_LOOKUP);

  sine_quarter_rom #(
    .TABLE_BITS (TABLE_BITS),
    .AMP_BITS   (AMP_BITS)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_rom_en),
    .i_idx  (w_idx),
    .o_data (w_sine)
  );

  // Raw waveform value for the latched mode
  always_comb begin
    w_wave = '0;
    case (r_mode)
      MODE_SINE:   w_wave = w_sine;
      MODE_SQUARE: w_wave = w_top[AMP_BITS-1] ? c_NEG_FS : c_POS_FS;
      MODE_SAW:    w_wave = {~w_top[AMP_BITS-1], w_top[AMP_BITS-2:0]};
      MODE_MUTE:   w_wave = '0;
      default:     w_wave = '0;
    endcase
  end

  // Signed x unsigned gain; floor shift back to unity scale
  assign w_wave_x     = {{9{w_wave[AMP_BITS-1]}}, w_wave};
  assign w_gain_x     = {{(AMP_BITS+1){1'b0}}, r_gain};
  assign w_prod       = w_wave_x * w_gain_x;
  assign w_scaled     = w_prod >>> GAIN_SHIFT;
  assign w_scaled_ext = {{(64-c_PROD_W){w_scaled[c_PROD_W-1]}}, w_scaled};

  // Frame sequencer with registered stream outputs and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ch      <= '0;
      r_mode    <= MODE_MUTE;
      r_gain    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_data    <= '0;
    end else begin
      if (i_sample_tick && r_busy) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_sample_tick) begin
            r_ch    <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          r_mode  <= w_mode[r_ch];
          r_gain  <= w_gain[r_ch];
          r_state <= ST_SCALE;
        end
        ST_SCALE: begin
          r_data  <= AMP_BITS'(saturate(w_scaled_ext, AMP_BITS));
          r_valid <= 1'b1;
          r_state <= ST_OUT;
        end
        ST_OUT: begin
          if (o_pcm.out_ready) begin
            r_valid <= 1'b0;
            if (r_ch == c_LAST_CH) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_ch    <= r_ch + c_CH_W'(1);
              r_state <= ST_LOOKUP;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_pcm.out_valid = r_valid;
  assign o_pcm.out_ch    = r_ch;
  assign o_pcm.out_data  = r_data;
  assign o_busy          = r_busy;
  assign o_overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_nco_multi_wave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nco_multi_wave
//  Description : Self-checking bench for nco_multi_wave with a phase/sample
//                reference model computed directly from waveform definitions.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nco_multi_wave;
  import nco_pkg::*;

  localparam int     NUM_CH = 2;
  localparam int     PB     = 24;
  localparam int     TBITS  = 8;
  localparam int     AB     = 16;
  localparam longint MOD    = 64'sd1 <<< PB;
  localparam longint FS     = 64'sd1 <<< (AB - 1);
  localparam real    PI     = 3.14159265358979323846;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     tick = 1'b0;
  logic                     clr = 1'b0;
  logic [NUM_CH*PB-1:0]     freq = '0;
  logic [NUM_CH*2-1:0]      mode = '1;
  logic [NUM_CH*8-1:0]      gain = '0;
  logic                     busy;
  logic                     ovr;

  nco_multi_wave_if #(.NUM_CH(NUM_CH), .AMP_BITS(AB)) pcm ();

  nco_multi_wave #(
    .NUM_CH (NUM_CH), .PHASE_BITS (PB), .TABLE_BITS (TBITS), .AMP_BITS (AB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_sample_tick (tick),
    .i_phase_clr   (clr),
    .i_freq_word   (freq),
    .i_mode        (mode),
    .i_gain        (gain),
    .o_pcm         (pcm),
    .o_busy        (busy),
    .o_overrun     (ovr)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint m_phase [NUM_CH];
  longint m_snap  [NUM_CH];
  longint m_freq  [NUM_CH];
  int     m_mode  [NUM_CH];
  int     m_gain  [NUM_CH];
  longint last    [NUM_CH];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected sample from the mathematical waveform definitions
  function automatic longint ref_sample(input longint ph, input int md, input int gn);
    real    v;
    longint s;
    longint p;
    case (md)
      0: begin
        v = real'(FS - 1) * $sin(2.0 * PI * (real'(ph >> (PB - TBITS)) + 0.5) / (2.0 ** TBITS));
        s = (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
      end
      1:       s = (ph >= MOD / 2) ? -(FS - 1) : (FS - 1);
      2:       s = (ph >> (PB - AB)) - FS;
      default: s = 0;
    endcase
    p = s * gn;
    p = (p >= 0) ? p / UNITY_GAIN : -((-p + UNITY_GAIN - 1) / UNITY_GAIN);
    if (p > FS - 1) p = FS - 1;
    if (p < -FS)    p = -FS;
    return p;
  endfunction

  task automatic set_cfg(input int ch, input longint f, input int md, input int g);
    m_freq[ch] = f;
    m_mode[ch] = md;
    m_gain[ch] = g;
    freq[ch*PB +: PB] = f[PB-1:0];
    mode[ch*2 +: 2]   = md[1:0];
    gain[ch*8 +: 8]   = g[7:0];
  endtask

  task automatic model_tick(input bit starts_frame);
    for (int c = 0; c < NUM_CH; c++) begin
      if (starts_frame) m_snap[c] = m_phase[c];
      m_phase[c] = (m_phase[c] + m_freq[c]) % MOD;
    end
  endtask

  task automatic phase_clear();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    for (int c = 0; c < NUM_CH; c++) m_phase[c] = 0;
  endtask

  // Wait (bounded) for out_valid; cyc = edges from the tick/handshake edge
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      tick = 1'b0;
      cyc++;
    end while (!pcm.out_valid && cyc < 20);
  endtask

  task automatic collect(input int from_ch, input int stall_max);
    int cyc;
    int k;
    logic signed [AB-1:0] d;
    for (int c = from_ch; c < NUM_CH; c++) begin
      wait_valid(cyc);
      check("latency", cyc, 3);
      check("out_ch", pcm.out_ch, c);
      check("out_data", pcm.out_data, ref_sample(m_snap[c], m_mode[c], m_gain[c]));
      last[c] = pcm.out_data;
      k = $urandom_range(0, stall_max);
      if (k > 0) begin
        d = pcm.out_data;
        pcm.out_ready = 1'b0;
        for (int j = 0; j < k; j++) begin
          @(negedge clk);
          check("stall_valid", pcm.out_valid, 1);
          check("stall_data", pcm.out_data, d);
        end
        pcm.out_ready = 1'b1;
      end
    end
    @(negedge clk);
    check("busy_end", busy, 0);
  endtask

  task automatic run_frame(input int stall_max);
    @(negedge clk);
    tick = 1'b1;
    model_tick(1'b1);
    collect(0, stall_max);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic signed [AB-1:0] d;
    pcm.out_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      m_phase[c] = 0; m_snap[c] = 0; set_cfg(c, 0, 3, 0);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", pcm.out_valid, 0);
    check("rst_data", pcm.out_data, 0);
    check("rst_ch", pcm.out_ch, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", ovr, 0);
    rst = 1'b0;

    // Sine at low frequency: first two table entries
    set_cfg(0, 24'h010000, 0, 128);
    set_cfg(1, 0, 3, 128);
    run_frame(0);
    check("sine_first", last[0], 402);
    run_frame(0);
    check("sine_second", last[0], 1206);

    // Half-rate sine alternates sign; muted channel stays zero
    phase_clear();
    set_cfg(0, 24'h800000, 0, 128);
    for (int f = 0; f < 4; f++) begin
      run_frame(0);
      check("half_rate", last[0], (f % 2 == 0) ? 402 : -402);
      check("mute", last[1], 0);
    end

    // Saturating square and saw at phase zero
    phase_clear();
    set_cfg(0, 24'h123456, 1, 255);
    set_cfg(1, 24'h0ABCDE, 2, 128);
    run_frame(2);
    check("square_sat", last[0], 32767);
    check("saw_zero", last[1], -32768);

    // Backpressure during ch0 with a tick landing mid-frame
    pcm.out_ready = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    model_tick(1'b1);
    wait_valid(cyc);
    check("bp_latency", cyc, 3);
    check("bp_ch0", pcm.out_data, ref_sample(m_snap[0], m_mode[0], m_gain[0]));
    d = pcm.out_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tick = (i == 4);
      if (i == 4) model_tick(1'b0);
      check("bp_valid", pcm.out_valid, 1);
      check("bp_hold_ch", pcm.out_ch, 0);
      check("bp_hold_data", pcm.out_data, d);
    end
    check("overrun_set", ovr, 1);
    pcm.out_ready = 1'b1;
    collect(1, 0);
    run_frame(0);

    // Wrapping accumulators
    phase_clear();
    set_cfg(0, 24'hFFFFFF, 0, 128);
    set_cfg(1, 24'hC00000, 0, 200);
    for (int f = 0; f < 5; f++) run_frame(0);

    // Random configurations with random backpressure
    for (int f = 0; f < 12; f++) begin
      for (int c = 0; c < NUM_CH; c++)
        set_cfg(c, longint'($urandom) % MOD, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      run_frame(2);
    end
    check("overrun_sticky", ovr, 1);

    // Reset while ch1 is in SCALE abandons the frame
    set_cfg(0, 24'h010000, 0, 128);
    set_cfg(1, 24'h200000, 2, 128);
    @(negedge clk);
    tick = 1'b1;
    model_tick(1'b1);
    wait_valid(cyc);
    check("rst_mid_ch0", pcm.out_data, ref_sample(m_snap[0], m_mode[0], m_gain[0]));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", pcm.out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_overrun", ovr, 0);
    check("rst_mid_data", pcm.out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) m_phase[c] = 0;
    run_frame(0);
    check("restart_ch0", last[0], 402);
    check("restart_ch1", last[1], -32768);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
